countdown_timer: RTL
====================

# countdown_timer

Programmable down-counting timer: the count-down counterpart to the team's loadable up-counter. It runs from a reload value to zero at a prescaled rate and signals expiry with a one-cycle pulse and a sticky flag. It supports one-shot and periodic (auto-reload) modes. It sits beside the up-counter in the processor peripheral space and drives interrupt and timeout logic.

## Interface
- COUNT_WIDTH, 8: width of reload value and count
- PRESCALE_WIDTH, 8: width of prescale divisor
- clk  in  1  system clock, rising-edge
- reset  in  1  synchronous, active-high; all state cleared on the clock edge
- load  in  1  write load_data into reload register and count
- load_data  in  COUNT_WIDTH  reload value R
- prescale  in  PRESCALE_WIDTH  divisor P; one tick every P+1 cycles; sampled only on start
- periodic  in  1  1 = auto-reload on expiry, 0 = one-shot; sampled only on start
- start  in  1  (re)start from reload value
- stop  in  1  halt; count frozen
- clear_underflow  in  1  clear sticky underflow flag
- count  out  COUNT_WIDTH  current count
- busy  out  1  state == RUN
- done  out  1  state == DONE (one-shot finished)
- expired  out  1  one-cycle pulse per expiry
- underflow  out  1  sticky expiry flag

## Operation
- Reset values: count 0, reload register 0, prescale counter 0, state IDLE, busy 0, done 0, expired 0, underflow 0, captured P 0, captured periodic 0.
- States and transitions:
  - IDLE: start -> RUN.
  - RUN: stop -> IDLE; one-shot expiry -> DONE; periodic expiry -> RUN; start -> RUN (restart).
  - DONE: start -> RUN; stop -> IDLE.
- start, in any state:
  - count <= reload register (or load_data if load is asserted in the same cycle).
  - prescale counter <= 0.
  - captures prescale and periodic.
- Prescaler (RUN only):
  - Counts 0..P and wraps.
  - A tick occurs in any cycle where the prescale counter equals the captured P.
  - P = 0 gives a tick every cycle.
- On a tick in RUN:
  - count != 0: count <= count - 1 (never wraps below 0).
  - count == 0: expiry.
    - Periodic: count <= reload register, stay RUN.
    - One-shot: count stays 0, go DONE.
- Expiry effects: expired pulses for one cycle and underflow sets.
- Period: (R+1)*(P+1) cycles. R = 0 expires on every tick.
- load, in any state:
  - Writes both the reload register and count.
  - Resets the prescale counter to 0.
  - State is unchanged.
  - load in RUN re-times the current period from the new value.
- Priority within one cycle: reset > stop > start > load > tick.
  - stop + start: stop wins, state IDLE, but load still applies if asserted.
  - load + tick: load wins, the tick is discarded.
- underflow: set by expiry, cleared by clear_underflow. Simultaneous set and clear: set wins.
- Arithmetic:
  - count decrement is modulo-free and saturating at 0.
  - The prescale counter is PRESCALE_WIDTH bits wide. P = all-ones is legal, giving 2^PRESCALE_WIDTH cycles per tick.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- start sampled at edge E0: busy = 1 and count = R after E0.
- Decrements occur at edges E(k*(P+1)) for k = 1..R. count reaches 0 after E(R*(P+1)).
- Expiry occurs at edge E((R+1)*(P+1)). expired is high for exactly the following cycle, and underflow is high from that edge.
- One-shot: busy falls and done rises at the expiry edge.
- Periodic: count = R after the expiry edge. The next expiry follows (R+1)*(P+1) cycles later.
- Reset mid-run: all outputs take their reset values after that edge. No expired pulse is generated, even if expiry coincides with reset.
- stop then start: restarts a full period; no partial prescale carry-over.

## Test plan
- Reset with load=1, start=1 asserted -> after the edge count=0, busy=0, underflow=0; no expired pulse.
- load_data=3, load; prescale=1, periodic=0, start -> count steps 3,2,1,0 every 2 cycles; expired single pulse 8 cycles after start; done=1, busy=0, count holds 0.
- load_data=2, prescale=0, periodic=1, start -> expired every 3 cycles for ≥4 periods; count sequence 2,1,0,2,1,0; busy stays 1.
- Periodic run, stop asserted at count=5 -> state IDLE, count frozen at 5 for 10 cycles. start -> count=R and a full period elapses before expiry.
- Periodic run: clear_underflow asserted in the same cycle as expiry -> underflow remains 1. clear_underflow alone next cycle -> underflow 0.
- RUN with R=10, P=3: load_data=2 + load mid-period -> count=2 immediately, prescale restarts, expiry 12 cycles later. start+stop same cycle -> IDLE.

Source files
------------

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module   : countdown_timer
//  Purpose  : Programmable down-counting timer. Counts from a reload value to
//             zero at a prescaled rate, then signals expiry with a one-cycle
//             pulse and a sticky flag. Supports one-shot and periodic
//             (auto-reload) operation.
//  Ports    :
//    clk             in   system clock, rising edge
//    reset           in   synchronous active-high reset
//    load            in   write load_data into reload register and count
//    load_data       in   reload value R
//    prescale        in   divisor P (one tick every P+1 cycles), captured on start
//    periodic        in   1 = auto-reload on expiry, captured on start
//    start           in   (re)start from the reload value
//    stop            in   halt, count frozen
//    clear_underflow in   clear sticky underflow flag
//    count           out  current count
//    busy            out  timer running
//    done            out  one-shot run finished
//    expired         out  one-cycle pulse per expiry
//    underflow       out  sticky expiry flag
//  Revision : 1.0  initial release
// ============================================================================
module countdown_timer #(
    parameter int COUNT_WIDTH    = 8,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [COUNT_WIDTH-1:0]    load_data,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      periodic,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      clear_underflow,
    output logic [COUNT_WIDTH-1:0]    count,
    output logic                      busy,
    output logic                      done,
    output logic                      expired,
    output logic                      underflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0]    c_cnt_zero = '0;
    localparam logic [COUNT_WIDTH-1:0]    c_cnt_one  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PRESCALE_WIDTH-1:0] c_psc_zero = '0;
    localparam logic [PRESCALE_WIDTH-1:0] c_psc_one  = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};

    state_t                      r_state,     w_state_nxt;
    logic [COUNT_WIDTH-1:0]      r_count,     w_count_nxt;
    logic [COUNT_WIDTH-1:0]      r_reload,    w_reload_nxt;
    logic [PRESCALE_WIDTH-1:0]   r_psc,       w_psc_nxt;
    logic [PRESCALE_WIDTH-1:0]   r_cap_p,     w_cap_p_nxt;
    logic                        r_cap_per,   w_cap_per_nxt;
    logic                        r_expired,   w_expired_nxt;
    logic                        r_underflow, w_underflow_nxt;
    logic                        w_tick;

    // The prescaler only advances while running; a tick marks the last
    // cycle of each P+1 cycle window.
    assign w_tick = (r_state == S_RUN) && (r_psc == r_cap_p);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_count     <= c_cnt_zero;
            r_reload    <= c_cnt_zero;
            r_psc       <= c_psc_zero;
            r_cap_p     <= c_psc_zero;
            r_cap_per   <= 1'b0;
            r_expired   <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_reload    <= w_reload_nxt;
            r_psc       <= w_psc_nxt;
            r_cap_p     <= w_cap_p_nxt;
            r_cap_per   <= w_cap_per_nxt;
            r_expired   <= w_expired_nxt;
            r_underflow <= w_underflow_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_reload_nxt    = r_reload;
        w_psc_nxt       = r_psc;
        w_cap_p_nxt     = r_cap_p;
        w_cap_per_nxt   = r_cap_per;
        w_expired_nxt   = 1'b0;
        w_underflow_nxt = r_underflow & ~clear_underflow;

        if (stop) begin
            // stop overrides start, but a simultaneous load still lands.
            w_state_nxt = S_IDLE;
            if (load) begin
                w_reload_nxt = load_data;
                w_count_nxt  = load_data;
                w_psc_nxt    = c_psc_zero;
            end
        end else if (start) begin
            w_state_nxt   = S_RUN;
            w_psc_nxt     = c_psc_zero;
            w_cap_p_nxt   = prescale;
            w_cap_per_nxt = periodic;
            if (load) begin
                w_reload_nxt = load_data;
                w_count_nxt  = load_data;
            end else begin
                w_count_nxt  = r_reload;
            end
        end else if (load) begin
            // A load in the same cycle as a tick discards the tick.
            w_reload_nxt = load_data;
            w_count_nxt  = load_data;
            w_psc_nxt    = c_psc_zero;
        end else if (r_state == S_RUN) begin
            if (w_tick) begin
                w_psc_nxt = c_psc_zero;
                if (r_count != c_cnt_zero) begin
                    w_count_nxt = r_count - c_cnt_one;
                end else begin
                    // Expiry: the set here overrides a simultaneous clear.
                    w_expired_nxt   = 1'b1;
                    w_underflow_nxt = 1'b1;
                    if (r_cap_per) begin
                        w_count_nxt = r_reload;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end else begin
                w_psc_nxt = r_psc + c_psc_one;
            end
        end
    end

    assign count     = r_count;
    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign expired   = r_expired;
    assign underflow = r_underflow;

endmodule
`default_nettype wire
